sar_comp_model: RTL and testbench
=================================

Name: sar_comp_model

Overview:
- Cycle-accurate digital model of the analog comparator and CDAC on the far side of the SAR controller's bit-trial interface.
- Responds to the controller's one-hot bit-trial strobes and trial register with the comparator decision OUTN.
- Holds the sampled input code and checks the controller's final code at the conversion-complete strobe.
- Used in block and top-level benches in place of the analog front end.

Parameters:
- N, 10, resolution in bits; matches the controller's D bus and phase-strobe count.
- OFFSET, 0, signed comparator offset in LSB, added to the sampled code (integer, range -2^N+1 .. 2^N-1).
- COMP_LAT, 1, cycles from PHASE strobe to DEC_VALID/OUTN update; must be >= 1.

Ports:
- CLKS  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- SAMPLE  in  1  one-cycle pulse; latch VIN_CODE and arm a conversion.
- VIN_CODE  in  N  digital stand-in for the analog input.
- PHASE  in  N  one-hot bit-trial strobe; PHASE[N-1] is the MSB trial (CLK10), PHASE[0] the LSB trial (CLK1).
- D  in  N  controller's current code register, sampled with each PHASE strobe and with CLKC.
- CLKC  in  1  conversion-complete strobe from the controller.
- OUTN  out  1  comparator decision; 1 = trial above input, controller clears the trial bit.
- DEC_VALID  out  1  one-cycle pulse when OUTN is updated.
- BUSY  out  1  high from SAMPLE until DONE or abort.
- DONE  out  1  one-cycle pulse when CLKC is accepted.
- MATCH  out  1  valid with DONE; 1 when D equals EXP_CODE.
- EXP_CODE  out  N  ideal expected result; updated at SAMPLE.
- SEQ_ERR  out  1  sticky protocol-violation flag; cleared only by RST.

Behaviour:
- Reset values: OUTN=0, DEC_VALID=0, BUSY=0, DONE=0, MATCH=0, EXP_CODE=0, SEQ_ERR=0, state IDLE, latency pipe flushed.
- Effective input: vin_eff = VIN_CODE + OFFSET, computed at N+2 bits signed and saturated to [0, 2^N-1]. vin_eff is latched into EXP_CODE on SAMPLE.
- FSM states:
  - IDLE: SAMPLE -> ARMED, BUSY=1.
  - ARMED: expect PHASE[N-1]; set k=N-1 and go to CONVERT.
  - CONVERT: on PHASE[k], trial = (D AND mask of bits above k) OR (1<<k); decision = (trial > EXP_CODE). Decision enters a COMP_LAT-deep pipe; on exit, OUTN<=decision and DEC_VALID=1. Then decrement k; after k=0 go to WAIT_END.
  - WAIT_END: when CLKC is seen and the pipe is empty: DONE=1, MATCH=(D==EXP_CODE), BUSY=0, go to IDLE.
- OUTN holds its last decision between updates. It is not cleared at SAMPLE.
- Protocol errors: each sets SEQ_ERR, flushes the pipe, forces IDLE and BUSY=0, and does not pulse DONE. The errors are:
  - PHASE not one-hot (more than one bit set).
  - Wrong PHASE bit for the current k.
  - Any PHASE strobe in IDLE or WAIT_END.
  - PHASE arriving while a decision is still in the pipe.
  - CLKC in ARMED or CONVERT, or CLKC in IDLE.
- PHASE all-zero is idle, not an error.
- Minimum PHASE spacing is therefore COMP_LAT+1 cycles.
- SAMPLE in any non-IDLE state restarts the conversion:
  - re-latch EXP_CODE, go to ARMED, flush the pipe, no DONE, no error.
  - SAMPLE takes priority over simultaneous PHASE or CLKC in the same cycle; those are ignored.
- RST has priority over everything, including mid-conversion and mid-pipe.
- Worst-case latency from SAMPLE to DONE with back-to-back strobes: 1 + N*(COMP_LAT+1) + 1 cycles.

Test Plan:
- N=10, OFFSET=0, COMP_LAT=1; SAMPLE with VIN=0x2A5; bench ideal-SAR driver strobes bits 9..0 and updates D from OUTN -> OUTN sequence 0,1,0,1,0,1,1,0,1,0; D ends at 0x2A5; DONE=1 with MATCH=1; SEQ_ERR=0.
- Saturation: OFFSET=+5 with VIN=0x3FF -> EXP_CODE=0x3FF, all ten OUTN=0. OFFSET=-5 with VIN=0x003 -> EXP_CODE=0x000, all OUTN=1.
- Faulty controller: correct sequence but bench flips D[0] before CLKC -> DONE=1, MATCH=0, SEQ_ERR=0.
- Order violation: PHASE[9] then PHASE[7] -> SEQ_ERR=1 on the cycle after PHASE[7], BUSY=0, no DONE. A later valid SAMPLE/conversion still completes; SEQ_ERR stays 1 until RST.
- Spacing/idle violations: PHASE on the cycle directly after a strobe with COMP_LAT=1, and a separate PHASE strobe in IDLE -> each sets SEQ_ERR; CLKC in IDLE -> SEQ_ERR, no DONE.
- Reset/restart: RST asserted after the bit-5 decision -> next cycle all outputs at reset values. SAMPLE with VIN=0x155 during bit 4 of a VIN=0x2A5 conversion -> EXP_CODE=0x155, conversion restarts at bit 9, single DONE with MATCH=1.

Source files
------------

// File: rtl/sar_comp_model_if.sv
// rtl/sar_comp_model_if.sv - bit-trial bus between the SAR controller and the comparator/CDAC model.
interface sar_comp_model_if #(
    parameter int N = 10
);
    logic         SAMPLE;
    logic [N-1:0] VIN_CODE;
    logic [N-1:0] PHASE;
    logic [N-1:0] D;
    logic         CLKC;
    logic         OUTN;
    logic         DEC_VALID;
    logic         BUSY;
    logic         DONE;
    logic         MATCH;
    logic [N-1:0] EXP_CODE;
    logic         SEQ_ERR;

    modport master (
        output SAMPLE, VIN_CODE, PHASE, D, CLKC,
        input  OUTN, DEC_VALID, BUSY, DONE, MATCH, EXP_CODE, SEQ_ERR
    );

    modport slave (
        input  SAMPLE, VIN_CODE, PHASE, D, CLKC,
        output OUTN, DEC_VALID, BUSY, DONE, MATCH, EXP_CODE, SEQ_ERR
    );
endinterface

// File: rtl/sar_comp_model.sv
// rtl/sar_comp_model.sv - cycle-accurate comparator/CDAC stand-in answering SAR bit trials.
module sar_comp_model #(
    parameter int N        = 10,
    parameter int OFFSET   = 0,
    parameter int COMP_LAT = 1
) (
    input  logic                CLKS,
    input  logic                RST,
    sar_comp_model_if.slave     bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [N+1:0] OFF_S = (N+2)'(OFFSET);

    typedef enum logic [1:0] {IDLE, ARMED, CONVERT, WAIT_END} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [COMP_LAT-1:0] pv_q, pv_d;
    logic [COMP_LAT-1:0] pd_q, pd_d;
    logic                outn_q, outn_d;
    logic                done_q, done_d;
    logic                match_q, match_d;
    logic                busy_q, busy_d;
    logic [N-1:0]        exp_q, exp_d;
    logic                err_q, err_d;

    logic signed [N+1:0] vin_sum;
    logic [N-1:0]        vin_eff;
    logic [N-1:0]        bit_k;
    logic [N-1:0]        trial;
    logic                decision;
    logic                pipe_busy;
    logic                multi_hot;
    logic                proto_err;
    logic                outn_now;

    // Saturate the offset-shifted input into the converter's code range.
    always_comb begin
        vin_sum = $signed({2'b00, bus.VIN_CODE}) + OFF_S;
        if (vin_sum[N+1])
            vin_eff = '0;
        else if (vin_sum[N])
            vin_eff = '1;
        else
            vin_eff = vin_sum[N-1:0];
    end

    assign outn_now = pv_q[COMP_LAT-1] ? pd_q[COMP_LAT-1] : outn_q;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pv_d      = pv_q << 1;
        pd_d      = pd_q << 1;
        outn_d    = outn_now;
        done_d    = 1'b0;
        match_d   = match_q;
        busy_d    = busy_q;
        exp_d     = exp_q;
        err_d     = err_q;
        proto_err = 1'b0;

        bit_k     = {{(N-1){1'b0}}, 1'b1} << k_q;
        trial     = (bus.D & ~((bit_k << 1) - {{(N-1){1'b0}}, 1'b1})) | bit_k;
        decision  = (trial > exp_q);
        pipe_busy = |pv_q;
        multi_hot = |(bus.PHASE & (bus.PHASE - {{(N-1){1'b0}}, 1'b1}));

        if (bus.SAMPLE) begin
            exp_d   = vin_eff;
            state_d = ARMED;
            k_d     = KW'(N-1);
            busy_d  = 1'b1;
            pv_d    = '0;
        end else begin
            if (|bus.PHASE) begin
                if (state_q == IDLE || state_q == WAIT_END || multi_hot ||
                    bus.PHASE != bit_k || pipe_busy) begin
                    proto_err = 1'b1;
                end else begin
                    pv_d[0] = 1'b1;
                    pd_d[0] = decision;
                    if (k_q == '0) begin
                        state_d = WAIT_END;
                    end else begin
                        k_d     = k_q - 1'b1;
                        state_d = CONVERT;
                    end
                end
            end
            if (bus.CLKC) begin
                if (state_q != WAIT_END) begin
                    proto_err = 1'b1;
                end else if (!pipe_busy && !proto_err) begin
                    done_d  = 1'b1;
                    match_d = (bus.D == exp_q);
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            if (proto_err) begin
                err_d   = 1'b1;
                pv_d    = '0;
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLKS) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= KW'(N-1);
            pv_q    <= '0;
            pd_q    <= '0;
            outn_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            outn_q  <= outn_d;
            done_q  <= done_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
        end
    end

    assign bus.OUTN      = outn_now;
    assign bus.DEC_VALID = pv_q[COMP_LAT-1];
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.MATCH     = match_q;
    assign bus.EXP_CODE  = exp_q;
    assign bus.SEQ_ERR   = err_q;
endmodule

// File: tb/tb_sar_comp_model.sv
// tb/tb_sar_comp_model.sv - ideal-SAR driver against three offset variants of sar_comp_model.
module tb_sar_comp_model;
    logic       clks = 1'b0;
    logic       rst;
    logic       sample;
    logic [9:0] vin_code;
    logic [9:0] phase;
    logic [9:0] d;
    logic       clkc;

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;
    int offs [3] = '{0, 5, -5};
    int exp_cur;
    int dreg;
    logic [9:0] seq;

    logic       outn_o, dv_o, busy_o, done_o, match_o, err_o;
    logic [9:0] exp_o;

    always #5 clks = ~clks;

    sar_comp_model_if #(.N(10)) i0 ();
    sar_comp_model_if #(.N(10)) ip ();
    sar_comp_model_if #(.N(10)) im ();

    assign i0.SAMPLE = sample; assign i0.VIN_CODE = vin_code; assign i0.PHASE = phase;
    assign i0.D = d;           assign i0.CLKC = clkc;
    assign ip.SAMPLE = sample; assign ip.VIN_CODE = vin_code; assign ip.PHASE = phase;
    assign ip.D = d;           assign ip.CLKC = clkc;
    assign im.SAMPLE = sample; assign im.VIN_CODE = vin_code; assign im.PHASE = phase;
    assign im.D = d;           assign im.CLKC = clkc;

    sar_comp_model #(.N(10), .OFFSET(0),  .COMP_LAT(1)) dut0 (.CLKS(clks), .RST(rst), .bus(i0));
    sar_comp_model #(.N(10), .OFFSET(5),  .COMP_LAT(1)) dutp (.CLKS(clks), .RST(rst), .bus(ip));
    sar_comp_model #(.N(10), .OFFSET(-5), .COMP_LAT(1)) dutm (.CLKS(clks), .RST(rst), .bus(im));

    always_comb begin
        case (sel)
            1: begin outn_o = ip.OUTN; dv_o = ip.DEC_VALID; busy_o = ip.BUSY; done_o = ip.DONE;
                     match_o = ip.MATCH; err_o = ip.SEQ_ERR; exp_o = ip.EXP_CODE; end
            2: begin outn_o = im.OUTN; dv_o = im.DEC_VALID; busy_o = im.BUSY; done_o = im.DONE;
                     match_o = im.MATCH; err_o = im.SEQ_ERR; exp_o = im.EXP_CODE; end
            default: begin outn_o = i0.OUTN; dv_o = i0.DEC_VALID; busy_o = i0.BUSY; done_o = i0.DONE;
                     match_o = i0.MATCH; err_o = i0.SEQ_ERR; exp_o = i0.EXP_CODE; end
        endcase
    end

    function automatic int clamp_code(input int vin, input int off);
        int v;
        v = vin + off;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    // Ideal comparator: the trial keeps resolved bits above k and tries bit k.
    function automatic logic model_dec(input int dcur, input int k, input int e);
        int trial;
        trial = (dcur & ~((1 << (k + 1)) - 1) & 1023) | (1 << k);
        return (trial > e);
    endfunction

    task automatic tick();
        @(posedge clks);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_outn"}, outn_o, 0);
        chk({tag, "_dv"}, dv_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_match"}, match_o, 0);
        chk({tag, "_exp"}, exp_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_err_clear", err_o, 0);
    endtask

    task automatic do_start(input int vin);
        sample = 1'b1;
        vin_code = vin[9:0];
        tick();
        sample = 1'b0;
        exp_cur = clamp_code(vin, offs[sel]);
        chk("exp_code", exp_o, exp_cur);
        chk("busy_start", busy_o, 1);
        dreg = 0;
    endtask

    task automatic do_bits(input int hi, input int lo);
        for (int k = hi; k >= lo; k--) begin
            dreg = dreg | (1 << k);
            d = dreg[9:0];
            phase = 10'(1 << k);
            tick();
            phase = '0;
            chk("dec_valid", dv_o, 1);
            chk("outn", outn_o, model_dec(dreg, k, exp_cur));
            seq[k] = outn_o;
            if (outn_o) dreg = dreg & ~(1 << k);
            d = dreg[9:0];
            tick();
            chk("dec_valid_low", dv_o, 0);
        end
    endtask

    task automatic do_finish(input bit flip, input bit exp_err);
        chk("final_d", dreg, exp_cur);
        d = flip ? (dreg[9:0] ^ 10'h001) : dreg[9:0];
        clkc = 1'b1;
        tick();
        clkc = 1'b0;
        chk("done", done_o, 1);
        chk("match", match_o, !flip);
        chk("busy_end", busy_o, 0);
        chk("seq_err", err_o, exp_err);
        tick();
        chk("done_single", done_o, 0);
    endtask

    initial begin
        rst = 1'b1; sample = 1'b0; vin_code = '0; phase = '0; d = '0; clkc = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Basic ideal conversion of 0x2A5.
        do_start(10'h2A5); do_bits(9, 0);
        chk("seq_2a5", seq, 10'h15A);
        do_finish(0, 0);

        // Saturation at both rails.
        sel = 1; do_start(10'h3FF); chk("sat_hi_exp", exp_o, 10'h3FF); do_bits(9, 0);
        chk("seq_sat_hi", seq, 10'h000); do_finish(0, 0);
        sel = 2; do_start(10'h003); chk("sat_lo_exp", exp_o, 10'h000); do_bits(9, 0);
        chk("seq_sat_lo", seq, 10'h3FF); do_finish(0, 0);
        sel = 0;

        // Faulty controller flips the LSB before CLKC.
        do_start(10'h1C3); do_bits(9, 0); do_finish(1, 0);

        // Order violation, then a valid conversion with SEQ_ERR sticky.
        do_start(10'h2A5); do_bits(9, 9);
        d = dreg[9:0] | 10'h080; phase = 10'h080;
        tick(); phase = '0;
        chk("order_err", err_o, 1); chk("order_busy", busy_o, 0); chk("order_done", done_o, 0);
        tick(); chk("order_done2", done_o, 0);
        do_start(10'h0F0); do_bits(9, 0); do_finish(0, 1);
        pulse_rst();

        // PHASE strobe while a decision is in the pipe.
        do_start(10'h100);
        d = 10'h200; phase = 10'h200; tick();
        phase = 10'h100; tick(); phase = '0;
        chk("spacing_err", err_o, 1); chk("spacing_busy", busy_o, 0);
        pulse_rst();

        // PHASE in IDLE.
        phase = 10'h200; tick(); phase = '0;
        chk("idle_phase_err", err_o, 1);
        pulse_rst();

        // CLKC in IDLE.
        clkc = 1'b1; tick(); clkc = 1'b0;
        chk("idle_clkc_err", err_o, 1); chk("idle_clkc_done", done_o, 0);
        pulse_rst();

        // Multi-hot PHASE.
        do_start(10'h200);
        phase = 10'h300; tick(); phase = '0;
        chk("multihot_err", err_o, 1); chk("multihot_busy", busy_o, 0);
        pulse_rst();

        // Reset while the bit-5 decision is in flight.
        do_start(10'h2A5); do_bits(9, 6);
        dreg = dreg | (1 << 5); d = dreg[9:0]; phase = 10'h020; tick(); phase = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_vals("midrst");

        // Restart by SAMPLE colliding with the bit-4 strobe.
        do_start(10'h2A5); do_bits(9, 5);
        dreg = dreg | (1 << 4); d = dreg[9:0];
        sample = 1'b1; vin_code = 10'h155; phase = 10'h010;
        tick();
        sample = 1'b0; phase = '0;
        exp_cur = 10'h155;
        chk("restart_exp", exp_o, 10'h155); chk("restart_dv", dv_o, 0); chk("restart_busy", busy_o, 1);
        dreg = 0;
        do_bits(9, 0); do_finish(0, 0);

        // Randomized conversions across the three offset variants.
        for (int i = 0; i < 8; i++) begin
            int vin;
            bit flip;
            sel  = int'($urandom_range(2, 0));
            vin  = int'($urandom_range(1023, 0));
            flip = 1'($urandom_range(1, 0));
            do_start(vin); do_bits(9, 0); do_finish(flip, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
